// File: rtl/fifo_write_ctrl_pkg.sv
// Shared types and default widths for the async FIFO write-side blocks.
package fifo_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } wctrl_state_t;

endpackage

// File: rtl/fifo_write_ctrl_if.sv
// Producer valid/ready stream into the FIFO write front end.
interface fifo_write_ctrl_if #(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;

  // producer side
  modport master (output s_valid, output s_data, input s_ready);
  // write controller side
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/fifo_write_ctrl_sat_counter.sv
// Saturating up-counter used for the debug statistics.
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  // count up on inc, stick at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (inc && (count != {CNT_WIDTH{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/fifo_write_ctrl.sv
// Write-side front end of the async FIFO: 2-entry skid buffer between a
// valid/ready producer and the winc/wdata pair, plus debug counters.
//
// state | meaning
// ------+---------------------------------------------
// EMPTY | no word buffered
// ONE   | one word in head
// TWO   | head and tail both hold words, s_ready low
module fifo_write_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fifo_write_ctrl_if.slave      s,
  input  logic                  halt,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  localparam logic [1:0] ST_EMPTY = EMPTY;
  localparam logic [1:0] ST_ONE   = ONE;
  localparam logic [1:0] ST_TWO   = TWO;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic                  ready;
  logic                  push;
  logic                  pop;
  logic                  stall;

  // ready depends on the state register only, so wfull never reaches s_ready
  assign ready     = (state != ST_TWO) & rst_n;
  assign s.s_ready = ready;
  assign push      = s.s_valid & ready;
  assign winc      = (state != ST_EMPTY) & ~halt & ~wfull;
  assign pop       = winc & ~wfull;
  assign wdata     = head;
  assign stall     = (state != ST_EMPTY) & wfull;

  // next occupancy from push/pop
  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (push)               state_nxt = ST_ONE;
      ST_ONE: begin
        if (push && !pop)               state_nxt = ST_TWO;
        else if (pop && !push)          state_nxt = ST_EMPTY;
      end
      ST_TWO:   if (pop)                state_nxt = ST_ONE;
      default:                          state_nxt = ST_EMPTY;
    endcase
  end

  // occupancy register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_EMPTY;
    else
      state <= state_nxt;
  end

  // head always feeds wdata; tail only fills when head is still waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else begin
      case (state)
        ST_EMPTY: if (push) head <= s.s_data;
        ST_ONE: begin
          if (push && pop)  head <= s.s_data;
          else if (push)    tail <= s.s_data;
        end
        ST_TWO:   if (pop)  head <= tail;
        default: ;
      endcase
    end
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_wr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pop),
    .count (wr_count)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall),
    .count (stall_count)
  );

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Directed bench for fifo_write_ctrl; a second instance with 4-bit
// counters shares the stimulus to exercise saturation.
module tb_fifo_write_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt;
  logic        wfull;
  logic        s_valid;
  logic [7:0]  s_data;

  logic        winc,  winc4;
  logic [7:0]  wdata, wdata4;
  logic [15:0] wr_count, stall_count;
  logic [3:0]  wr4, st4;

  int vectors     = 0;
  int miscompares = 0;
  int exp_wr;
  int exp_stall;
  int occ;
  logic exp_winc;
  logic accepted;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  fifo_write_ctrl_if #(.DATA_WIDTH(8)) s_if ();
  fifo_write_ctrl_if #(.DATA_WIDTH(8)) s4_if ();

  assign s_if.s_valid  = s_valid;
  assign s_if.s_data   = s_data;
  assign s4_if.s_valid = s_valid;
  assign s4_if.s_data  = s_data;

  fifo_write_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s           (s_if),
    .halt        (halt),
    .wfull       (wfull),
    .winc        (winc),
    .wdata       (wdata),
    .wr_count    (wr_count),
    .stall_count (stall_count)
  );

  fifo_write_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .s           (s4_if),
    .halt        (halt),
    .wfull       (wfull),
    .winc        (winc4),
    .wdata       (wdata4),
    .wr_count    (wr4),
    .stall_count (st4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    // reset with a producer already asserting valid
    rst_n = 1'b0; halt = 1'b0; wfull = 1'b0; s_valid = 1'b1; s_data = 8'h55;
    tick(); tick(); #1;
    chk("rst_ready",  s_if.s_ready, 0);
    chk("rst_winc",   winc, 0);
    chk("rst_wdata",  wdata, 0);
    chk("rst_wrcnt",  wr_count, 0);
    chk("rst_stall",  stall_count, 0);
    tick(); rst_n = 1'b1; s_valid = 1'b0; #1;
    chk("rel_ready",  s_if.s_ready, 1);

    // streaming 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      tick(); s_valid = 1'b1; s_data = 8'(i); #1;
      chk("str_ready", s_if.s_ready, 1);
      chk("str_winc",  winc, (i > 1) ? 1 : 0);
      if (i > 1) chk("str_wdata", wdata, i - 1);
    end
    tick(); s_valid = 1'b0; #1;
    chk("str_winc_last",  winc, 1);
    chk("str_wdata_last", wdata, 8'h10);
    tick(); #1;
    chk("str_idle",   winc, 0);
    chk("str_wrcnt",  wr_count, 16);
    chk("str_wrcnt4", wr4, 15);

    // backpressure
    tick(); wfull = 1'b1; s_valid = 1'b1; s_data = 8'hA0; #1;
    chk("bp_ready0", s_if.s_ready, 1);
    chk("bp_winc0",  winc, 0);
    tick(); s_data = 8'hA1; #1;
    chk("bp_ready1", s_if.s_ready, 1);
    chk("bp_winc1",  winc, 0);
    tick(); s_data = 8'hA2; #1;
    chk("bp_ready2", s_if.s_ready, 0);
    chk("bp_stall1", stall_count, 1);
    for (int i = 0; i < 4; i++) tick();
    #1;
    chk("bp_stall5", stall_count, 5);
    chk("bp_hold",   winc, 0);
    wfull = 1'b0; #1;
    chk("bp_out0_v", winc, 1);
    chk("bp_out0",   wdata, 8'hA0);
    tick(); #1;
    chk("bp_ready3", s_if.s_ready, 1);
    chk("bp_out1_v", winc, 1);
    chk("bp_out1",   wdata, 8'hA1);
    tick(); s_valid = 1'b0; #1;
    chk("bp_out2_v", winc, 1);
    chk("bp_out2",   wdata, 8'hA2);
    tick(); #1;
    chk("bp_idle",   winc, 0);
    chk("bp_wrcnt",  wr_count, 19);
    chk("bp_stall",  stall_count, 5);

    // random pushes with wfull toggling, checked against a scoreboard
    exp_wr = 19; exp_stall = 5; accepted = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      wfull = i[0];
      if (!s_valid || accepted) begin
        s_valid = 1'($urandom_range(0, 1));
        s_data  = 8'($urandom_range(0, 255));
      end
      #1;
      occ = q.size();
      exp_winc = (occ != 0) && !wfull;
      chk("rnd_winc",  winc, exp_winc);
      chk("rnd_ready", s_if.s_ready, (occ < 2) ? 1 : 0);
      if (exp_winc) begin
        chk("rnd_wdata", wdata, q[0]);
        void'(q.pop_front());
        exp_wr++;
      end
      if (occ != 0 && wfull) exp_stall++;
      accepted = s_valid && (occ < 2);
      if (accepted) q.push_back(s_data);
    end
    tick(); wfull = 1'b0; s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      #1;
      exp_winc = (q.size() != 0);
      chk("drn_winc", winc, exp_winc);
      if (exp_winc) begin
        chk("drn_wdata", wdata, q[0]);
        void'(q.pop_front());
        exp_wr++;
      end
    end
    chk("rnd_wrcnt", wr_count, exp_wr);
    chk("rnd_stall", stall_count, exp_stall);

    // halt with two words buffered
    tick(); halt = 1'b1; s_valid = 1'b1; s_data = 8'hB0; #1;
    chk("hlt_winc0", winc, 0);
    tick(); s_data = 8'hB1; #1;
    chk("hlt_winc1", winc, 0);
    tick(); s_valid = 1'b0; #1;
    chk("hlt_full",  s_if.s_ready, 0);
    chk("hlt_winc2", winc, 0);
    tick(); #1;
    chk("hlt_winc3", winc, 0);
    chk("hlt_stall", stall_count, exp_stall);
    chk("hlt_wrcnt", wr_count, exp_wr);
    halt = 1'b0; #1;
    chk("hlt_out0_v", winc, 1);
    chk("hlt_out0",   wdata, 8'hB0);
    tick(); #1;
    chk("hlt_out1_v", winc, 1);
    chk("hlt_out1",   wdata, 8'hB1);
    tick(); #1;
    exp_wr += 2;
    chk("hlt_idle",   winc, 0);
    chk("hlt_wrcnt2", wr_count, exp_wr);

    // saturation of the 4-bit instance
    chk("sat_wr4",    wr4, 15);
    chk("sat_st4",    st4, (exp_stall > 15) ? 15 : exp_stall);

    // reset with two words buffered
    tick(); wfull = 1'b1; s_valid = 1'b1; s_data = 8'hC0;
    tick(); s_data = 8'hC1;
    tick(); s_valid = 1'b0; #1;
    chk("mrs_two", s_if.s_ready, 0);
    tick(); rst_n = 1'b0; wfull = 1'b0; #1;
    chk("mrs_ready", s_if.s_ready, 0);
    chk("mrs_winc",  winc, 0);
    chk("mrs_wdata", wdata, 0);
    chk("mrs_wrcnt", wr_count, 0);
    chk("mrs_stall", stall_count, 0);
    chk("mrs_wr4",   wr4, 0);
    tick(); rst_n = 1'b1; #1;
    chk("mrs_rel_ready", s_if.s_ready, 1);
    chk("mrs_rel_winc",  winc, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
